grover_diffusion: RTL

GROVER_DIFFUSION -- requirements
Module: grover_diffusion

---
 rtl/grover_diffusion.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/grover_diffusion.sv
// Grover diffusion step over eight signed 8-bit amplitudes: o_k = sat8(2*mean - i_k).
// The vector is captured on accept, summed one element per cycle, then reflected one element per cycle.
module grover_diffusion (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] i0,
   input  logic [7:0] i1,
   input  logic [7:0] i2,
   input  logic [7:0] i3,
   input  logic [7:0] i4,
   input  logic [7:0] i5,
   input  logic [7:0] i6,
   input  logic [7:0] i7,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] o0,
   output logic [7:0] o1,
   output logic [7:0] o2,
   output logic [7:0] o3,
   output logic [7:0] o4,
   output logic [7:0] o5,
   output logic [7:0] o6,
   output logic [7:0] o7,
   output logic       sat,
   output logic       busy,
   output logic [1:0] dbg_state
);

   // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
   // valid never waits on ready, and a producer holds its data until the transfer edge.
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCUM = 2'd1, S_REFLECT = 2'd2, S_DONE = 2'd3} state_t;

   state_t             state_q, state_d;
   logic        [2:0]  k_q, k_d;
   logic        [10:0] acc_q, acc_d;
   logic        [7:0]  mean_q, mean_d;
   logic               sat_q, sat_d;
   logic        [7:0]  vec_q [8];
   logic        [7:0]  vec_d [8];
   logic        [7:0]  o_q [8];
   logic        [7:0]  o_d [8];

   logic        [7:0]  elem;
   logic        [10:0] acc_sum;
   logic        [9:0]  diff;
   logic        [7:0]  clip;
   logic               clipped;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         acc_q   <= '0;
         mean_q  <= '0;
         sat_q   <= 1'b0;
         for (int n = 0; n < 8; n++) begin
            vec_q[n] <= '0;
            o_q[n]   <= '0;
         end
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         acc_q   <= acc_d;
         mean_q  <= mean_d;
         sat_q   <= sat_d;
         vec_q   <= vec_d;
         o_q     <= o_d;
      end
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      acc_d   = acc_q;
      mean_d  = mean_q;
      sat_d   = sat_q;
      vec_d   = vec_q;
      o_d     = o_q;

      elem    = vec_q[k_q];
      acc_sum = acc_q + {{3{elem[7]}}, elem};
      // 2*mean - x spans -383..382, so 10 bits hold it without wrap.
      diff    = {mean_q[7], mean_q, 1'b0} - {{2{elem[7]}}, elem};
      clipped = 1'b0;
      if (!diff[9] && (diff[8:7] != 2'b00)) begin
         clip    = 8'h7f;
         clipped = 1'b1;
      end else if (diff[9] && (diff[8:7] != 2'b11)) begin
         clip    = 8'h80;
         clipped = 1'b1;
      end else begin
         clip = diff[7:0];
      end

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               state_d  = S_ACCUM;
               k_d      = 3'd0;
               acc_d    = '0;
               sat_d    = 1'b0;
               vec_d[0] = i0;
               vec_d[1] = i1;
               vec_d[2] = i2;
               vec_d[3] = i3;
               vec_d[4] = i4;
               vec_d[5] = i5;
               vec_d[6] = i6;
               vec_d[7] = i7;
            end
         end
         S_ACCUM: begin
            acc_d = acc_sum;
            k_d   = k_q + 3'd1;
            if (k_q == 3'd7) begin
               // Upper bits of the sum are the floor of sum/8.
               mean_d  = acc_sum[10:3];
               state_d = S_REFLECT;
            end
         end
         S_REFLECT: begin
            o_d[k_q] = clip;
            if (clipped) sat_d = 1'b1;
            k_d = k_q + 3'd1;
            if (k_q == 3'd7) state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = rst_n && (state_q == S_IDLE);
      busy      = (state_q != S_IDLE);
      out_valid = (state_q == S_DONE);
      sat       = sat_q;
      dbg_state = state_q;
      o0        = o_q[0];
      o1        = o_q[1];
      o2        = o_q[2];
      o3        = o_q[3];
      o4        = o_q[4];
      o5        = o_q[5];
      o6        = o_q[6];
      o7        = o_q[7];
   end

endmodule
